// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port unified memory between CPU and loader.
// Define MEM_ARB_LOCK_EN to build the bounded loader lock FSM; otherwise ld_lock is ignored.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wmask,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                ld_req,
    input  logic                ld_we,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_wdata,
    input  logic [DATA_W/8-1:0] ld_wmask,
    output logic                ld_gnt,
    output logic                ld_rvalid,
    output logic [DATA_W-1:0]   ld_rdata,
    input  logic                ld_lock,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int MW = DATA_W / 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MW-1:0]     wmask;
    } req_t;

    typedef enum logic [1:0] {OPEN, LOCKED, EXPIRED} lock_state_t;

    lock_state_t state;
    logic        rr;        // 0 = CPU wins a tie, 1 = loader wins a tie
    logic        rd_pend;
    logic        rd_owner;  // 0 = CPU, 1 = loader
    logic        locked;
    req_t        cpu_r, ld_r, sel_r;

    assign locked = (state == LOCKED);
    assign cpu_r  = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, wmask: cpu_wmask};
    assign ld_r   = '{we: ld_we, addr: ld_addr, wdata: ld_wdata, wmask: ld_wmask};

    // Grants are held low during reset so every output reads 0 while it is asserted.
    always_comb begin
        cpu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (!reset) begin
            if (locked) begin
                ld_gnt = ld_req;
            end else if (cpu_req && ld_req) begin
                cpu_gnt = ~rr;
                ld_gnt  = rr;
            end else begin
                cpu_gnt = cpu_req;
                ld_gnt  = ld_req;
            end
        end
    end

    always_comb begin
        sel_r = '0;
        if (cpu_gnt)     sel_r = cpu_r;
        else if (ld_gnt) sel_r = ld_r;
    end

    assign mem_en    = cpu_gnt | ld_gnt;
    assign mem_we    = sel_r.we;
    assign mem_addr  = sel_r.addr;
    assign mem_wdata = sel_r.wdata;
    assign mem_wmask = sel_r.wmask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr       <= 1'b0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (mem_en && !locked) rr <= cpu_gnt;
            rd_pend <= mem_en & ~mem_we;
            if (mem_en && !mem_we) rd_owner <= ld_gnt;
        end
    end

    assign cpu_rvalid = rd_pend & ~rd_owner;
    assign ld_rvalid  = rd_pend & rd_owner;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;

`ifdef MEM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_LOCK);

    logic [CW-1:0] lock_cnt;

    // The grant that opens the lock counts as the first of the MAX_LOCK grants.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= OPEN;
            lock_cnt <= '0;
        end else begin
            case (state)
                OPEN: if (ld_gnt && ld_lock) begin
                    lock_cnt <= CW'(1);
                    state    <= (MAX_LOCK == 1) ? EXPIRED : LOCKED;
                end
                LOCKED: if (!ld_lock) begin
                    state <= OPEN;
                end else if (ld_gnt) begin
                    lock_cnt <= lock_cnt + CW'(1);
                    if (lock_cnt + CW'(1) == LAST) state <= EXPIRED;
                end
                EXPIRED: if (!ld_lock) state <= OPEN;
                default: state <= OPEN;
            endcase
        end
    end
`else
    logic lock_unused;
    assign state       = OPEN;
    assign lock_unused = ld_lock ^ (MAX_LOCK != 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, reads, writes, contention and lock behaviour.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wmask;
    logic        ld_req, ld_we, ld_gnt, ld_rvalid, ld_lock;
    logic [31:0] ld_addr, ld_wdata, ld_rdata;
    logic [3:0]  ld_wmask;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wmask(cpu_wmask), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_wmask(ld_wmask), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ld_lock(ld_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] rdfun(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory macro model: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= rdfun(mem_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [13:0] exp_cpu;

    initial begin
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; cpu_wdata = '0; cpu_wmask = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_wmask = '0; ld_lock = 1'b0;

        // During reset: request pending yet every output is 0
        @(negedge clk);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("pre_rst_gnt", cpu_gnt, 1);
        chk("pre_rst_addr", mem_addr, 32'h10);
        next_cycle();
        // Read is in flight; reset must drop it
        reset = 1'b1;
        #1;
        chk("midrd_cpu_rvalid", cpu_rvalid, 0);
        chk("midrd_cpu_rdata", cpu_rdata, 0);
        chk("midrd_cpu_gnt", cpu_gnt, 0);
        chk("midrd_mem_en", mem_en, 0);
        next_cycle();
        reset = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", cpu_rvalid, 0);
        chk("post_rst_mem_en", mem_en, 0);

        // Tie after reset: rr starts at CPU
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h20; ld_req = 1'b1; ld_addr = 32'h24;
        @(negedge clk);
        chk("tie_cpu_gnt", cpu_gnt, 1);
        chk("tie_ld_gnt", ld_gnt, 0);
        next_cycle();
        cpu_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        chk("tie_cpu_rvalid", cpu_rvalid, 1);
        chk("tie_cpu_rdata", cpu_rdata, rdfun(32'h20));
        chk("tie_ld_rvalid", ld_rvalid, 0);

        // Single CPU read
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h40;
        @(negedge clk);
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_mem_en", mem_en, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_mem_addr", mem_addr, 32'h40);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_ld_rvalid", ld_rvalid, 0);
        chk("rd_ld_rdata", ld_rdata, 0);
        chk("rd_idle_mem_en", mem_en, 0);

        // Loader write (rr now points at loader; leaves it at CPU)
        next_cycle();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h100; ld_wdata = 32'h12345678; ld_wmask = 4'b0011;
        @(negedge clk);
        chk("wr_ld_gnt", ld_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 32'h100);
        chk("wr_mem_wdata", mem_wdata, 32'h12345678);
        chk("wr_mem_wmask", mem_wmask, 4'b0011);
        next_cycle();
        ld_req = 1'b0; ld_we = 1'b0;
        @(negedge clk);
        chk("wr_cpu_rvalid", cpu_rvalid, 0);
        chk("wr_ld_rvalid", ld_rvalid, 0);

        // Contention: six cycles of reads from both ports
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h200; ld_req = 1'b1; ld_addr = 32'h300; ld_wmask = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("ct%0d_cpu_gnt", i), cpu_gnt, (i % 2 == 0));
            chk($sformatf("ct%0d_ld_gnt", i), ld_gnt, (i % 2 == 1));
            if (i > 0) begin
                chk($sformatf("ct%0d_cpu_rvalid", i), cpu_rvalid, (i % 2 == 1));
                chk($sformatf("ct%0d_ld_rvalid", i), ld_rvalid, (i % 2 == 0));
                chk($sformatf("ct%0d_rdata", i), (i % 2 == 1) ? cpu_rdata : ld_rdata,
                    (i % 2 == 1) ? rdfun(32'h200) : rdfun(32'h300));
            end
            next_cycle();
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        @(negedge clk);
        chk("ct_last_ld_rvalid", ld_rvalid, 1);
        chk("ct_last_ld_rdata", ld_rdata, rdfun(32'h300));
        chk("ct_last_cpu_rdata", cpu_rdata, 0);

        // Lock stimulus: both ports writing, ld_lock high except one cycle (i=10)
`ifdef MEM_ARB_LOCK_EN
        exp_cpu = 14'b00_1010_1010_0001;
`else
        exp_cpu = 14'b01_0101_0101_0101;
`endif
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b1; ld_req = 1'b1; ld_we = 1'b1;
        for (int i = 0; i < 14; i++) begin
            ld_lock = (i != 10);
            @(negedge clk);
            chk($sformatf("lk%0d_cpu_gnt", i), cpu_gnt, exp_cpu[i]);
            chk($sformatf("lk%0d_ld_gnt", i), ld_gnt, !exp_cpu[i]);
            next_cycle();
        end
        cpu_req = 1'b0; ld_req = 1'b0; ld_lock = 1'b0; cpu_we = 1'b0; ld_we = 1'b0;
        @(negedge clk);
        chk("end_mem_en", mem_en, 0);
        chk("end_rvalid", cpu_rvalid | ld_rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end
endmodule
